// File: rtl/lfsr_gen.sv
// -----------------------------------------------------------------------------
// lfsr_gen -- Fibonacci LFSR pseudo-random generator with period tracking.
//
// The register shifts toward the MSB; the new LSB is the XOR of the state bits
// selected by the feedback mask. A WIDTH-bit step counter tracks the position
// within the period and raises a one-cycle wrap pulse when the state returns to
// the value it started from after reset or load.
//
// Parameters
//   WIDTH : register width, 4..16 when the built-in mask is used
//   SEED  : reset value of the state (0 is coerced to 1)
//   TAPS  : feedback mask; 0 selects the built-in maximal-length mask
//
// Ports
//   clk      in   clock, all state updates on the rising edge
//   rst      in   asynchronous active-high reset
//   en       in   advance the LFSR one step
//   load     in   load seed_in (wins over en)
//   seed_in  in   seed captured on load (0 is coerced to 1)
//   data_out out  current LFSR state (register output)
//   bit_out  out  serial output, data_out[WIDTH-1]
//   wrap     out  one-cycle pulse: full period completed since reset/load
//   seed_err out  one-cycle pulse: a load with seed_in == 0 occurred
// -----------------------------------------------------------------------------
module lfsr_gen #(
    parameter int          WIDTH = 4,
    parameter int unsigned SEED  = 1,
    parameter int unsigned TAPS  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] data_out,
    output logic             bit_out,
    output logic             wrap,
    output logic             seed_err
);

    // Maximal-length masks for the supported widths; 0 marks "no built-in".
    function automatic logic [31:0] builtin_mask(input int w);
        logic [31:0] m;
        m = 32'h0;
        case (w)
            4:  m = 32'h000C;
            5:  m = 32'h0014;
            6:  m = 32'h0030;
            7:  m = 32'h0060;
            8:  m = 32'h00B8;
            9:  m = 32'h0110;
            10: m = 32'h0240;
            11: m = 32'h0500;
            12: m = 32'h0829;
            13: m = 32'h100D;
            14: m = 32'h2015;
            15: m = 32'h6000;
            16: m = 32'hD008;
            default: m = 32'h0;
        endcase
        return m;
    endfunction

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width_any
            $error("lfsr_gen: WIDTH %0d is not supported", WIDTH);
        end
        if ((WIDTH < 4 || WIDTH > 16) && TAPS == 0) begin : g_bad_width_builtin
            $error("lfsr_gen: no built-in mask for WIDTH %0d; supply TAPS", WIDTH);
        end
    endgenerate

    localparam logic [31:0]      TAPS_L    = TAPS;
    localparam logic [31:0]      BUILTIN_L = builtin_mask(WIDTH);
    localparam logic [31:0]      MASK_L    = (TAPS == 0) ? BUILTIN_L : TAPS_L;
    localparam logic [WIDTH-1:0] MASK      = MASK_L[WIDTH-1:0];

    localparam logic [31:0]      SEED_L    = SEED;
    // A zero seed would lock the register at 0, so it is replaced by 1.
    localparam logic [WIDTH-1:0] SEED_EFF  = (SEED_L[WIDTH-1:0] == '0) ?
                                             WIDTH'(1) : SEED_L[WIDTH-1:0];

    // Counter value on the last step of a period (2^WIDTH - 2); the step taken
    // from here returns the state to its starting value.
    localparam logic [WIDTH-1:0] CNT_LAST  = {{(WIDTH-1){1'b1}}, 1'b0};

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] cnt_q,   cnt_d;
    logic             wrap_q,  wrap_d;
    logic             seed_err_q, seed_err_d;
    logic             fb;

    assign fb = ^(state_q & MASK);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wrap_d     = 1'b0;
        seed_err_d = 1'b0;
        if (load) begin
            cnt_d = '0;
            if (seed_in == '0) begin
                state_d    = WIDTH'(1);
                seed_err_d = 1'b1;
            end else begin
                state_d = seed_in;
            end
        end else if (en) begin
            state_d = {state_q[WIDTH-2:0], fb};
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                wrap_d = 1'b1;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SEED_EFF;
            cnt_q      <= '0;
            wrap_q     <= 1'b0;
            seed_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wrap_q     <= wrap_d;
            seed_err_q <= seed_err_d;
        end
    end

    assign data_out = state_q;
    assign bit_out  = state_q[WIDTH-1];
    assign wrap     = wrap_q;
    assign seed_err = seed_err_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// -----------------------------------------------------------------------------
// tb_lfsr_gen -- self-checking bench for lfsr_gen.
// A 4-bit instance is exercised with a directed vector table, hand-written
// reset/enable sequences and random stimulus against a step-count model; an
// 8-bit instance is free-run over one full period.
// -----------------------------------------------------------------------------
module tb_lfsr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-bit instance
    logic       rst, en, load;
    logic [3:0] seed_in, data_out;
    logic       bit_out, wrap, seed_err;

    // 8-bit instance
    logic       rst8, en8, load8;
    logic [7:0] seed8, data8;
    logic       bit8, wrap8, err8;

    lfsr_gen #(.WIDTH(4), .SEED(1), .TAPS(0)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in),
        .data_out(data_out), .bit_out(bit_out), .wrap(wrap), .seed_err(seed_err)
    );

    lfsr_gen #(.WIDTH(8), .SEED(1), .TAPS(0)) dut8 (
        .clk(clk), .rst(rst8), .en(en8), .load(load8), .seed_in(seed8),
        .data_out(data8), .bit_out(bit8), .wrap(wrap8), .seed_err(err8)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- reference model (4-bit, mask 0xC) ----------------
    // The state follows the shift-and-parity rule; wrap is derived from the
    // number of steps since reset/load being a multiple of the period.
    localparam int PERIOD = 15;
    int m_state, m_steps;
    bit m_wrap, m_err;

    function automatic int next_state(input int s);
        int fb;
        fb = $countones(s & 'hC) % 2;
        return ((s * 2) % 16) + fb;
    endfunction

    task automatic model_reset();
        m_state = 1; m_steps = 0; m_wrap = 0; m_err = 0;
    endtask

    task automatic model_apply(input bit l, input bit e, input int s);
        m_wrap = 0;
        m_err  = 0;
        if (l) begin
            m_state = (s == 0) ? 1 : s;
            m_err   = (s == 0);
            m_steps = 0;
        end else if (e) begin
            m_state = next_state(m_state);
            m_steps++;
            m_wrap  = (m_steps % PERIOD == 0);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/data"}, data_out, m_state);
        chk({tag, "/bit"},  bit_out,  (m_state / 8) % 2);
        chk({tag, "/wrap"}, wrap,     m_wrap);
        chk({tag, "/err"},  seed_err, m_err);
    endtask

    // Drive one cycle of inputs, then sample 1 ns after the rising edge.
    task automatic cyc(input string tag, input bit l, input bit e, input int s);
        load = l; en = e; seed_in = 4'(s);
        @(posedge clk); #1;
        model_apply(l, e, s);
        check_all(tag);
    endtask

    task automatic do_reset();
        load = 0; en = 0; seed_in = 0;
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       ld;
        logic       e;
        logic [3:0] seed;
        logic [3:0] d;
        logic       w;
        logic       er;
    } vec_t;

    vec_t       vt[20];
    logic [3:0] seq[15];

    bit seen[256];
    int wstep, nseen;
    logic [3:0] rs;
    bit rl, re;

    initial begin
        seq = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
        for (int i = 0; i < 15; i++)
            vt[i] = '{1'b0, 1'b1, 4'h0, seq[i], (i == 14), 1'b0};
        vt[15] = '{1'b1, 1'b1, 4'h9, 4'h9, 1'b0, 1'b0};   // load wins over en
        vt[16] = '{1'b0, 1'b1, 4'h0, 4'h3, 1'b0, 1'b0};
        vt[17] = '{1'b1, 1'b1, 4'h0, 4'h1, 1'b0, 1'b1};   // zero seed coerced
        vt[18] = '{1'b0, 1'b0, 4'h5, 4'h1, 1'b0, 1'b0};   // hold clears pulse
        vt[19] = '{1'b0, 1'b1, 4'h0, 4'h2, 1'b0, 1'b0};

        rst = 1; en = 0; load = 0; seed_in = 0;
        rst8 = 1; en8 = 0; load8 = 0; seed8 = 0;
        model_reset();

        // Reset state, with en/load active to show they are ignored.
        @(negedge clk); en = 1; load = 1; seed_in = 4'h6;
        @(posedge clk); #1;
        chk("reset/data", data_out, 1);
        chk("reset/bit",  bit_out,  0);
        chk("reset/wrap", wrap,     0);
        chk("reset/err",  seed_err, 0);
        load = 0; en = 0;
        @(negedge clk); rst = 0; rst8 = 0;

        // Table: full period, load priority, zero-seed load.
        for (int i = 0; i < 20; i++) begin
            load = vt[i].ld; en = vt[i].e; seed_in = vt[i].seed;
            @(posedge clk); #1;
            model_apply(vt[i].ld, vt[i].e, int'(vt[i].seed));
            chk($sformatf("vec%0d/data", i), data_out, vt[i].d);
            chk($sformatf("vec%0d/wrap", i), wrap,     vt[i].w);
            chk($sformatf("vec%0d/err", i),  seed_err, vt[i].er);
        end

        // Period after a zero-seed load is still 15.
        wstep = -1;
        for (int i = 2; i <= 16; i++) begin
            cyc("zseed", 0, 1, 0);
            if (wrap && wstep < 0) wstep = i;
        end
        chk("zseed/period", wstep, 15);

        // Asynchronous reset after 7 steps.
        do_reset();
        for (int i = 0; i < 7; i++) cyc("pre_arst", 0, 1, 0);
        chk("arst/pre", data_out, 4'hA);
        #2 rst = 1;
        #1 chk("arst/immediate", data_out, 1);
        chk("arst/wrap", wrap, 0);
        load = 1; seed_in = 4'h7; en = 1;
        @(posedge clk); #1;
        chk("arst/ignored", data_out, 1);
        @(negedge clk); rst = 0; load = 0;
        model_reset();
        wstep = -1;
        for (int i = 1; i <= 20; i++) begin
            cyc("post_arst", 0, 1, 0);
            if (wrap && wstep < 0) wstep = i;
        end
        chk("arst/wrap_step", wstep, 15);

        // Alternating enable: wrap follows the 15th enabled step.
        do_reset();
        wstep = -1;
        for (int i = 0; i < 30; i++) begin
            cyc("alt", 0, (i % 2) == 0, 0);
            if (wrap && wstep < 0) wstep = i;
        end
        chk("alt/wrap_cycle", wstep, 28);

        // Random load/en/seed against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rl = ($urandom_range(0, 9) == 0);
            re = ($urandom_range(0, 3) != 0);
            rs = 4'($urandom_range(0, 15));
            cyc("rand", rl, re, int'(rs));
        end

        // 8-bit free run over one full period.
        for (int v = 0; v < 256; v++) seen[v] = 0;
        seen[data8] = 1;
        chk("w8/start", data8, 1);
        en8 = 1;
        for (int i = 1; i <= 255; i++) begin
            @(posedge clk); #1;
            checks++;
            if (data8 != 0 && (!seen[data8] || (i == 255 && data8 == 1))) passes++;
            else $display("FAIL w8/unique step %0d: got %0h expected unseen nonzero", i, data8);
            seen[data8] = 1;
            chk($sformatf("w8/wrap%0d", i), wrap8, (i == 255));
        end
        en8 = 0;
        nseen = 0;
        for (int v = 1; v < 256; v++) if (seen[v]) nseen++;
        chk("w8/count", nseen, 255);
        chk("w8/zero_unseen", seen[0], 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
